// File: rtl/tomasula_types.sv
// Shared Tomasulo datapath types: the ALU operand bundle carried from the
// reservation stations to the ALU, plus scheduler constants.
// Optional feature macro used by the scheduler: RS_AGE_PRIORITY_EN.
package tomasula_types;

  localparam int TAG_W  = 4;
  localparam int OPC_W  = 4;
  localparam int DATA_W = 16;

  // Age counters saturate here when age-priority issue is built in.
  localparam int         RS_AGE_W   = 3;
  localparam logic [2:0] RS_AGE_MAX = 3'd7;

  // One ALU operation as held by a reservation station.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
  } alu_word;

  // One-entry output stage towards the ALU/CDB slot.
  typedef enum logic {
    OS_IDLE = 1'b0,
    OS_HOLD = 1'b1
  } out_state_e;

endpackage

// File: rtl/rs_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after ptr,
// wrapping modulo NUM_RS. Purely combinational; reusable for CDB arbitration.
module rr_arbiter #(
  parameter int NUM_RS = 4,
  parameter int IDX_W  = $clog2(NUM_RS)
) (
  input  logic [NUM_RS-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_RS-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  logic             w_found;
  logic [IDX_W:0]   w_cand;

  // Walk the stations in rotating order starting at ptr; first requester wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      w_cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_RS)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_RS);
      end
      if (en && !w_found && req[w_cand[IDX_W-1:0]]) begin
        w_found                   = 1'b1;
        gnt[w_cand[IDX_W-1:0]]    = 1'b1;
        idx                       = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: steers dispatch into the lowest free
// station, picks one ready station per cycle for the shared ALU slot and
// holds the winning operand bundle in a one-entry valid/ready output stage.
// Optional feature macro: RS_AGE_PRIORITY_EN (oldest requester issues first,
// ties broken in round-robin order). Default build is pure round-robin.
module rs_issue_scheduler
  import tomasula_types::*;
#(
  parameter int NUM_RS = 4,
  parameter int IDX_W  = $clog2(NUM_RS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_valid,
  output logic              dispatch_stall,
  output logic [NUM_RS-1:0] load_word,
  input  logic [NUM_RS-1:0] res_empty,
  input  logic [NUM_RS-1:0] exe_req,
  input  alu_word           rs_alu_data [NUM_RS],
  output logic [NUM_RS-1:0] exe_grant,
  output alu_word           alu_out,
  output logic              alu_valid,
  input  logic              alu_ready,
  input  logic              flush,
  output logic [IDX_W-1:0]  grant_idx
);

  out_state_e        r_state;
  out_state_e        w_state_nxt;
  alu_word           r_alu_out;
  logic              r_rst_d;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_last_idx;

  logic              w_gate;
  logic              w_can_accept;
  logic              w_issue_en;
  logic              w_any_grant;
  logic [NUM_RS-1:0] w_low_empty;
  logic [NUM_RS-1:0] w_arb_req;
  logic [NUM_RS-1:0] w_gnt;
  logic [IDX_W-1:0]  w_idx;

  // Outputs stay quiet during reset and for one cycle after it.
  assign w_gate = rst | r_rst_d;

  // Remember that reset was just seen, to mask the first cycle after it.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    r_rst_d <= rst;
  end

  // ---------------------------------------------------------------- dispatch
  // Lowest set bit of res_empty via two's-complement isolation.
  assign w_low_empty    = res_empty & (~res_empty + NUM_RS'(1));
  assign load_word      = (dispatch_valid && !flush && !w_gate) ? w_low_empty : '0;
  assign dispatch_stall = dispatch_valid & ~(|res_empty) & ~w_gate;

  // ----------------------------------------------------------- output stage
  assign alu_valid    = (r_state == OS_HOLD);
  assign alu_out      = r_alu_out;
  assign w_can_accept = ~alu_valid | alu_ready;
  assign w_issue_en   = w_can_accept & ~flush & ~w_gate;

  // ------------------------------------------------------- request shaping
`ifdef RS_AGE_PRIORITY_EN
  logic [RS_AGE_W-1:0] r_age [NUM_RS];
  logic [RS_AGE_W-1:0] w_age_max;

  // Only the requesters carrying the largest age compete in the arbiter.
  always_comb begin
    w_age_max = '0;
    w_arb_req = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (exe_req[i] && (r_age[i] > w_age_max)) begin
        w_age_max = r_age[i];
      end
    end
    for (int i = 0; i < NUM_RS; i++) begin
      w_arb_req[i] = exe_req[i] && (r_age[i] == w_age_max);
    end
  end

  // Per-station age: cleared on load, bumped each cycle spent waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: a small per-station register array is reset explicitly; larger
      // storage arrays would be left unreset and qualified by valid bits.
      for (int i = 0; i < NUM_RS; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (load_word[i]) begin
          r_age[i] <= '0;
        end else if (exe_req[i] && !w_gnt[i] && (r_age[i] != RS_AGE_MAX)) begin
          r_age[i] <= r_age[i] + RS_AGE_W'(1);
        end
      end
    end
  end
`else
  assign w_arb_req = exe_req;
`endif

  // ------------------------------------------------------------------ issue
  rr_arbiter #(
    .NUM_RS (NUM_RS),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req (w_arb_req),
    .ptr (r_rr_ptr),
    .en  (w_issue_en),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  assign w_any_grant = |w_gnt;
  assign exe_grant   = w_gnt;
  assign grant_idx   = w_any_grant ? w_idx : r_last_idx;

  // Output-stage state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next output-stage state: flush drops the slot, a grant fills it, an
  // accept without refill empties it, otherwise the held op waits.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = OS_IDLE;
    end else if (w_any_grant) begin
      w_state_nxt = OS_HOLD;
    end else if (alu_ready) begin
      w_state_nxt = OS_IDLE;
    end
  end

  // Capture the granted bundle and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out  <= '0;
      r_rr_ptr   <= '0;
      r_last_idx <= '0;
    end else if (w_any_grant) begin
      r_alu_out  <= rs_alu_data[w_idx];
      r_last_idx <= w_idx;
      r_rr_ptr   <= (w_idx == IDX_W'(NUM_RS-1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: a cycle-level reference model
// of the dispatch/issue rules checked every cycle, plus directed vectors with
// hand-computed expectations. Honours RS_AGE_PRIORITY_EN when defined.
module tb_rs_issue_scheduler;
  import tomasula_types::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          dispatch_valid;
  logic          dispatch_stall;
  logic [N-1:0]  load_word;
  logic [N-1:0]  res_empty;
  logic [N-1:0]  exe_req;
  alu_word       rs_alu_data [N];
  logic [N-1:0]  exe_grant;
  alu_word       alu_out;
  logic          alu_valid;
  logic          alu_ready;
  logic          flush;
  logic [IW-1:0] grant_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rs_issue_scheduler #(.NUM_RS(N), .IDX_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .dispatch_valid (dispatch_valid),
    .dispatch_stall (dispatch_stall),
    .load_word      (load_word),
    .res_empty      (res_empty),
    .exe_req        (exe_req),
    .rs_alu_data    (rs_alu_data),
    .exe_grant      (exe_grant),
    .alu_out        (alu_out),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .flush          (flush),
    .grant_idx      (grant_idx)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int      m_rr    = 0;
  int      m_last  = 0;
  logic    m_valid = 1'b0;
  alu_word m_out   = '0;
  logic    m_post  = 1'b1;
  int      m_age [N] = '{default: 0};

  always @(negedge clk) begin : model_cmp
    logic         gate, can, found;
    logic [N-1:0] e_load, e_gnt;
    logic         e_stall;
    int           pick, best, s, e_idx;

    gate   = rst || m_post;
    e_load = '0;
    found  = 1'b0;
    if (!gate && !flush && dispatch_valid) begin
      for (int i = 0; i < N; i++) begin
        if (res_empty[i] && !found) begin
          e_load[i] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    e_stall = !gate && dispatch_valid && (res_empty == '0);
    can     = !m_valid || alu_ready;
    pick    = -1;
    best    = -1;
    if (!gate && can && !flush) begin
      for (int k = 0; k < N; k++) begin
        s = (m_rr + k) % N;
        if (exe_req[s]) begin
`ifdef RS_AGE_PRIORITY_EN
          if (m_age[s] > best) begin
            best = m_age[s];
            pick = s;
          end
`else
          if (pick < 0) pick = s;
`endif
        end
      end
    end
    e_gnt = (pick >= 0) ? (N'(1) << pick) : '0;
    e_idx = (pick >= 0) ? pick : m_last;

    check("load_word", 64'(load_word), 64'(e_load));
    check("dispatch_stall", 64'(dispatch_stall), 64'(e_stall));
    check("exe_grant", 64'(exe_grant), 64'(e_gnt));
    check("grant_idx", 64'(grant_idx), 64'(e_idx));
    check("alu_valid", 64'(alu_valid), 64'(m_valid));
    check("alu_out", 64'(alu_out), 64'(m_out));

    // State the DUT will hold after the coming rising edge.
    for (int i = 0; i < N; i++) begin
      if (rst) m_age[i] = 0;
      else if (e_load[i]) m_age[i] = 0;
      else if (exe_req[i] && !e_gnt[i] && m_age[i] < 7) m_age[i] = m_age[i] + 1;
    end
    if (rst) begin
      m_rr = 0; m_last = 0; m_valid = 1'b0; m_out = '0; m_post = 1'b1;
    end else begin
      m_post = 1'b0;
      if (flush) begin
        m_valid = 1'b0;
      end else if (pick >= 0) begin
        m_out   = rs_alu_data[pick];
        m_valid = 1'b1;
        m_rr    = (pick + 1) % N;
        m_last  = pick;
      end else if (alu_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [TAG_W-1:0] tag_of(input int i);
    return TAG_W'(4'hA + i);
  endfunction

  initial begin
    rst = 1'b1; dispatch_valid = 1'b0; res_empty = '0; exe_req = '0;
    alu_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      rs_alu_data[i] = '{tag: tag_of(i), opcode: OPC_W'(i + 1),
                         src_a: DATA_W'(16'h1000 + i), src_b: DATA_W'(16'h2000 + i)};
    end
    repeat (3) tick();

    // Reset release: first cycle after reset is still masked.
    rst = 1'b0; dispatch_valid = 1'b1; res_empty = 4'b1010;
    settle();
    check("post_rst_load", 64'(load_word), 64'h0);
    check("post_rst_valid", 64'(alu_valid), 64'h0);
    tick();
    settle();
    check("disp_load_1010", 64'(load_word), 64'b0010);
    check("disp_nostall", 64'(dispatch_stall), 64'h0);
    tick();
    res_empty = 4'b0000;
    settle();
    check("disp_stall", 64'(dispatch_stall), 64'h1);
    check("disp_noload", 64'(load_word), 64'h0);
    tick();

    // All stations ready, ALU always accepting.
    dispatch_valid = 1'b0; exe_req = 4'b1111; alu_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      settle();
`ifndef RS_AGE_PRIORITY_EN
      check("rr_grant", 64'(exe_grant), 64'(N'(1) << k));
      check("rr_idx", 64'(grant_idx), 64'(k));
      if (k > 0) check("rr_tag", 64'(alu_out.tag), 64'(tag_of(k - 1)));
`endif
      check("rr_valid", 64'(alu_valid), 64'(k > 0));
      tick();
    end

    // Grant station 2, then hold it under backpressure.
    exe_req = 4'b0100;
    settle();
    check("g2_grant", 64'(exe_grant), 64'b0100);
    tick();
    alu_ready = 1'b0; exe_req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_nogrant", 64'(exe_grant), 64'h0);
      check("bp_valid", 64'(alu_valid), 64'h1);
      check("bp_tag", 64'(alu_out.tag), 64'(tag_of(2)));
      tick();
    end
    alu_ready = 1'b1;
    settle();
    check("bp_release", 64'(exe_grant), 64'b0001);
    tick();

    // Flush while the output slot is full.
    flush = 1'b1; exe_req = 4'b0100; dispatch_valid = 1'b1; res_empty = 4'b1111;
    settle();
    check("fl_nogrant", 64'(exe_grant), 64'h0);
    check("fl_noload", 64'(load_word), 64'h0);
    check("fl_idx_hold", 64'(grant_idx), 64'h0);
    tick();
    flush = 1'b0; dispatch_valid = 1'b0; exe_req = 4'b0000; alu_ready = 1'b0;
    settle();
    check("fl_valid_drop", 64'(alu_valid), 64'h0);
    tick();
    exe_req = 4'b0101; alu_ready = 1'b1;
    settle();
`ifndef RS_AGE_PRIORITY_EN
    check("fl_ptr_kept", 64'(exe_grant), 64'b0100);
`endif
    tick();

    // Reset in the middle of operation discards the held op.
    exe_req = 4'b0001; alu_ready = 1'b0;
    tick();
    rst = 1'b1; exe_req = 4'b0000;
    tick();
    rst = 1'b0; exe_req = 4'b0001;
    settle();
    check("mid_rst_valid", 64'(alu_valid), 64'h0);
    check("mid_rst_out", 64'(alu_out), 64'h0);
    check("mid_rst_nogrant", 64'(exe_grant), 64'h0);
    tick();

`ifdef RS_AGE_PRIORITY_EN
    // Station 3 waits longest while 0/1 alternate under backpressure.
    exe_req = 4'b0001; alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exe_req = (k % 2 == 0) ? 4'b1001 : 4'b1010;
      tick();
    end
    alu_ready = 1'b1; exe_req = 4'b1011;
    settle();
    check("age_oldest", 64'(exe_grant), 64'b1000);
    tick();
`endif

    // Mixed traffic, checked by the model every cycle.
    for (int k = 0; k < 80; k++) begin
      rst            = ($urandom_range(0, 39) == 0);
      flush          = ($urandom_range(0, 7) == 0);
      dispatch_valid = $urandom_range(0, 1) == 1;
      res_empty      = N'($urandom_range(0, 15));
      exe_req        = N'($urandom_range(0, 15));
      alu_ready      = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        rs_alu_data[i] = alu_word'($urandom());
        rs_alu_data[i].tag = TAG_W'($urandom_range(0, 15));
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; exe_req = '0; dispatch_valid = 1'b0;
    tick();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
